// File: rtl/conv_para_window_acc.sv
// Parallel window MAC: PARA_Y x PARA_X lanes times one broadcast weight over K*K*C beats, then bias/round/saturate/ReLU.
// Latency: result 2 edges after the final beat; in_ready only in RUN; result held until out_ready.
module conv_para_window_acc #(
    parameter int PARA_X     = 3,
    parameter int PARA_Y     = 3,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_WIDTH  = 40,
    parameter int KERNEL_MAX = 7,
    parameter int CH_WIDTH   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [3:0]                           cfg_kernel_size,
    input  logic [CH_WIDTH-1:0]                  cfg_in_channels,
    input  logic                                 cfg_relu,
    input  logic [DATA_WIDTH-1:0]                bias,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [1:0]                           in_mode,
    input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  input_data,
    input  logic [DATA_WIDTH-1:0]                weight,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0]  result_buffer,
    output logic                                 busy
);

    localparam int NL   = PARA_X * PARA_Y;
    localparam int PW   = 2 * DATA_WIDTH;
    localparam int KK_W = $clog2(KERNEL_MAX * KERNEL_MAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    logic [2:0]                   state_q, state_d;
    logic [KK_W-1:0]              kk_last_q, kk_last_d;
    logic [KK_W-1:0]              kpos_q, kpos_d;
    logic [CH_WIDTH-1:0]          ch_last_q, ch_last_d;
    logic [CH_WIDTH-1:0]          ch_q, ch_d;
    logic                         relu_q, relu_d;
    logic signed [DATA_WIDTH-1:0] bias_q, bias_d;
    logic signed [DATA_WIDTH-1:0] weight_q, weight_d;
    logic                         mac_vld_q, mac_vld_d;
    logic signed [DATA_WIDTH-1:0] win_q [NL];
    logic signed [DATA_WIDTH-1:0] win_d [NL];
    logic signed [ACC_WIDTH-1:0]  acc_q [NL];
    logic signed [ACC_WIDTH-1:0]  acc_d [NL];
    logic [DATA_WIDTH-1:0]        res_q [NL];
    logic [DATA_WIDTH-1:0]        res_d [NL];

    logic [3:0]        k_eff;
    logic              accept;
    logic signed [PW-1:0] prod;

    function automatic logic [DATA_WIDTH-1:0] finish_lane(
        input logic signed [ACC_WIDTH-1:0]  a,
        input logic signed [DATA_WIDTH-1:0] b,
        input logic                         relu
    );
        logic signed [ACC_WIDTH-1:0] s;
        logic signed [ACC_WIDTH-1:0] r;
        logic [DATA_WIDTH-1:0]       o;
        s = a + ({{(ACC_WIDTH-DATA_WIDTH){b[DATA_WIDTH-1]}}, b} <<< FRAC_BITS)
              + (ACC_WIDTH'(1) <<< (FRAC_BITS - 1));
        r = s >>> FRAC_BITS;
        // Fits when every bit above the result's sign bit agrees with it.
        if ((&r[ACC_WIDTH-1:DATA_WIDTH-1]) || ~(|r[ACC_WIDTH-1:DATA_WIDTH-1]))
            o = r[DATA_WIDTH-1:0];
        else if (r[ACC_WIDTH-1])
            o = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            o = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        if (relu && o[DATA_WIDTH-1])
            o = '0;
        return o;
    endfunction

    assign in_ready  = (state_q == S_RUN);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q != S_IDLE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        if (cfg_kernel_size == 4'd0)
            k_eff = 4'd1;
        else if (cfg_kernel_size > 4'(KERNEL_MAX))
            k_eff = 4'(KERNEL_MAX);
        else
            k_eff = cfg_kernel_size;
    end

    always_comb begin
        state_d   = state_q;
        kk_last_d = kk_last_q;
        kpos_d    = kpos_q;
        ch_last_d = ch_last_q;
        ch_d      = ch_q;
        relu_d    = relu_q;
        bias_d    = bias_q;
        weight_d  = weight_q;
        mac_vld_d = 1'b0;
        win_d     = win_q;
        acc_d     = acc_q;
        res_d     = res_q;
        prod      = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kk_last_d = KK_W'(k_eff) * KK_W'(k_eff) - KK_W'(1);
                    ch_last_d = (cfg_in_channels == '0) ? '0 : cfg_in_channels - CH_WIDTH'(1);
                    relu_d    = cfg_relu;
                    bias_d    = bias;
                    kpos_d    = '0;
                    ch_d      = '0;
                    for (int l = 0; l < NL; l++) acc_d[l] = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    weight_d  = weight;
                    mac_vld_d = 1'b1;
                    case (in_mode)
                        2'b00: begin
                            for (int l = 0; l < NL; l++)
                                win_d[l] = input_data[l*DATA_WIDTH +: DATA_WIDTH];
                        end
                        2'b01: begin
                            for (int y = 0; y < PARA_Y; y++)
                                for (int x = 0; x < PARA_X; x++)
                                    win_d[y*PARA_X+x] = (x < PARA_X-1) ? win_q[y*PARA_X+x+1]
                                                      : input_data[y*DATA_WIDTH +: DATA_WIDTH];
                        end
                        2'b10: begin
                            for (int y = 0; y < PARA_Y; y++)
                                for (int x = 0; x < PARA_X; x++)
                                    win_d[y*PARA_X+x] = (y < PARA_Y-1) ? win_q[(y+1)*PARA_X+x]
                                                      : input_data[x*DATA_WIDTH +: DATA_WIDTH];
                        end
                        default: ;
                    endcase
                    if (kpos_q == kk_last_q) begin
                        kpos_d = '0;
                        ch_d   = ch_q + CH_WIDTH'(1);
                        if (ch_q == ch_last_q)
                            state_d = S_DRAIN;
                    end else begin
                        kpos_d = kpos_q + KK_W'(1);
                    end
                end
            end
            S_DRAIN: state_d = S_FINAL;
            S_FINAL: begin
                for (int l = 0; l < NL; l++)
                    res_d[l] = finish_lane(acc_q[l], bias_q, relu_q);
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Second MAC stage: consumes the window/weight registered on the previous accepted beat.
        if (mac_vld_q) begin
            for (int l = 0; l < NL; l++) begin
                prod     = PW'(win_q[l]) * PW'(weight_q);
                acc_d[l] = acc_q[l] + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
            end
        end
    end

    always_comb begin
        result_buffer = '0;
        for (int l = 0; l < NL; l++)
            result_buffer[l*DATA_WIDTH +: DATA_WIDTH] = res_q[l];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            kk_last_q <= '0;
            kpos_q    <= '0;
            ch_last_q <= '0;
            ch_q      <= '0;
            relu_q    <= 1'b0;
            bias_q    <= '0;
            weight_q  <= '0;
            mac_vld_q <= 1'b0;
            for (int l = 0; l < NL; l++) begin
                win_q[l] <= '0;
                acc_q[l] <= '0;
                res_q[l] <= '0;
            end
        end else begin
            state_q   <= state_d;
            kk_last_q <= kk_last_d;
            kpos_q    <= kpos_d;
            ch_last_q <= ch_last_d;
            ch_q      <= ch_d;
            relu_q    <= relu_d;
            bias_q    <= bias_d;
            weight_q  <= weight_d;
            mac_vld_q <= mac_vld_d;
            win_q     <= win_d;
            acc_q     <= acc_d;
            res_q     <= res_d;
        end
    end

endmodule
